uart_tx: RTL and testbench
==========================

// Module: uart_tx
// PURPOSE
//  Standalone UART transmitter: serialises bytes from a syn/ack request port onto txd.
//  Frame format is runtime-configured, with the same config inputs as the UART receive path.
//  Pairs with the receive path for loopback and target-facing TX in the CW/TraceWhisperer UART.
//  Frames: start(0), LSB-first data, optional parity, 1-2 stop bits(1).
// PARAMETERS
//  pBR_WIDTH  16  width of bit_rate / baud counter
// PORTS
//  clk              in   1          single clock domain
//  reset_n          in   1          asynchronous, active-low reset
//  bit_rate         in   pBR_WIDTH  bit period = bit_rate+1 clk cycles
//  data_bits        in   4          data bits per frame; 1..8 valid; 0 or >8 -> 8
//  stop_bits        in   2          0,1 -> one stop bit; 2,3 -> two
//  parity_bit       in   1          0 = even, 1 = odd
//  parity_enabled   in   1          1 = insert parity bit after data
//  txd_syn          in   1          request: txd_data valid, send a frame
//  txd_data         in   8          byte to send; bits above data_bits ignored
//  txd_ack          out  1          1-cycle pulse: txd_data captured
//  txd              out  1          serial line, idle high
//  tx_busy          out  1          high from capture until end of last stop bit
// BEHAVIOUR
//  Reset (async): txd=1, txd_ack=0, tx_busy=0, state=IDLE, counters=0. txd goes high
//   immediately, even mid-frame. Aborted frame not resumed, no ack replayed.
//  States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE, or STOP -> START.
//  IDLE: txd=1. txd_syn=1 at edge N -> at N+1: txd_ack=1 for one cycle, txd=0, tx_busy=1,
//   state START. Data, bit_rate, clamped data_bits, stop count and parity cfg latched at N.
//   Later config changes affect only the next frame.
//  txd_syn is sampled only in IDLE or on the final cycle of STOP. The requester deasserts it
//   any time after txd_ack; holding it high sends txd_data again.
//  Baud counter loads bit_rate at each bit start and decrements. Bit ends on the cycle
//   the counter is 0, so every bit is exactly bit_rate+1 cycles. bit_rate=0 gives 1 cycle/bit.
//  DATA: shift latched byte LSB first; bit counter runs 0..D-1, then PARITY if enabled, else STOP.
//  PARITY: txd = ^data[D-1:0] ^ parity_bit. Only the D sent bits count.
//  STOP: txd=1 for S bit periods. On the final cycle: txd_syn=1 -> back-to-back, START
//   next cycle with ack and no idle gap. Otherwise IDLE, tx_busy=0.
//  Frame length = (1+D+P+S)*(bit_rate+1) clk, measured from the first txd=0 cycle.
//  txd is driven from a flop, never combinational, so it is glitch-free.
//  txd_ack and the start-bit txd=0 appear in the same cycle.
// STRUCTURE
//  Shared include uart_defines.v: state encodings, DATA_BITS_MAX=8, STOP_BITS_MAX=2, and the
//   data_bits/stop_bits clamp functions. The receive path uses the same include.
//  One sub-module: uart_baud_cnt, a loadable down-counter with a bit_done strobe.
//   Reusable by the receive path.
//  Remaining FSM, shift register and bit/stop counters stay inline. Target 150-250 lines.
// TESTING
//  Loopback bench: txd drives the receive path's rxd. Direct sampling of txd with
//   a bit-period model. Error counter exported to the cocotb wrapper.
//  T1 8N1: bit_rate=3, data 0xA5 -> txd = 0,1,0,1,0,0,1,0,1,1, each held 4 clk.
//   Frame 40 clk. Ack 1 cycle after syn. Receive path reports 0xA5.
//  T2 parity: 8 data bits, odd parity, 0xA5 -> parity bit 1. Even parity -> 0.
//   data_bits=7, even parity, 0xFF -> 7 ones sent, parity 1, bit 7 never sent.
//  T3 2 stop bits, syn held high, 0x00 then 0xFF -> second start bit follows stop bit 2 with
//   no gap. Exactly 2 acks. Frame spacing (1+8+2)*(bit_rate+1).
//  T4 clamp: data_bits=0 and data_bits=12 -> 8 data bits. stop_bits=0 -> 1, stop_bits=3 -> 2.
//   bit_rate=0 -> 1 clk/bit frame correct.
//  T5 reset mid-DATA: reset_n low during bit 3 -> txd=1 the same cycle, no ack. After release
//   a new request sends a clean full frame.
//  T6 config change mid-frame: bit_rate 3 -> 7 during DATA -> current frame stays at
//   4 clk/bit. Next frame uses 8 clk/bit.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared UART frame definitions: state encoding, frame limits and config clamp helpers.
// Imported by both the transmit and receive paths.
package uart_tx_pkg;

    localparam int unsigned DATA_BITS_MAX = 8;
    localparam int unsigned STOP_BITS_MAX = 2;
    localparam int unsigned DB_W          = 4;
    localparam int unsigned SB_W          = 2;
    localparam int unsigned BIT_CNT_W     = 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // Frame shape latched at capture; data_bits and stop_bits hold clamped counts.
    typedef struct packed {
        logic [DB_W-1:0] data_bits;
        logic [SB_W-1:0] stop_bits;
        logic            parity_en;
    } frame_cfg_t;

    function automatic logic [DB_W-1:0] clamp_data_bits(input logic [DB_W-1:0] d);
        if (d == '0 || d > DB_W'(DATA_BITS_MAX)) return DB_W'(DATA_BITS_MAX);
        return d;
    endfunction

    function automatic logic [SB_W-1:0] clamp_stop_bits(input logic [SB_W-1:0] s);
        return (s >= SB_W'(STOP_BITS_MAX)) ? SB_W'(STOP_BITS_MAX) : SB_W'(1);
    endfunction

    // d must already be clamped to 1..DATA_BITS_MAX.
    function automatic logic [DATA_BITS_MAX-1:0] data_mask(input logic [DB_W-1:0] d);
        return {DATA_BITS_MAX{1'b1}} >> (DB_W'(DATA_BITS_MAX) - d);
    endfunction

endpackage

// File: rtl/uart_tx_baud_cnt.sv
// Loadable bit-period down-counter; bit_done_c is high on the last cycle of each bit.
// A load of N yields a bit of exactly N+1 cycles.
module uart_tx_baud_cnt #(
    parameter int unsigned pBR_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 load,
    input  logic [pBR_WIDTH-1:0] load_val,
    output logic                 bit_done_c
);

    logic [pBR_WIDTH-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - pBR_WIDTH'(1);
        end
    end

    assign bit_done_c = (cnt == '0);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: captures a byte on a syn/ack handshake and sends start, LSB-first data,
// optional parity and 1-2 stop bits on a registered txd line.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int unsigned pBR_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [pBR_WIDTH-1:0] bit_rate,
    input  logic [DB_W-1:0]      data_bits,
    input  logic [SB_W-1:0]      stop_bits,
    input  logic                 parity_bit,
    input  logic                 parity_enabled,
    input  logic                 txd_syn,
    input  logic [7:0]           txd_data,
    output logic                 txd_ack,
    output logic                 txd,
    output logic                 tx_busy
);

    tx_state_e            state;
    tx_state_e            state_nxt;
    frame_cfg_t           cfg_q;
    frame_cfg_t           cfg_c;
    logic [7:0]           shreg;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [SB_W-1:0]      stop_cnt;
    logic [pBR_WIDTH-1:0] br_q;
    logic                 par_q;
    logic                 par_c;
    logic                 capture_c;
    logic                 bit_done_c;
    logic                 data_last_c;
    logic                 stop_last_c;
    logic                 baud_load_c;
    logic [pBR_WIDTH-1:0] baud_val_c;
    logic                 txd_nxt;
    logic                 ack_nxt;
    logic                 busy_nxt;

    // Frame config and parity as they will be latched if a request is taken this cycle.
    assign cfg_c = '{data_bits: clamp_data_bits(data_bits),
                     stop_bits: clamp_stop_bits(stop_bits),
                     parity_en: parity_enabled};
    assign par_c = (^(txd_data & data_mask(cfg_c.data_bits))) ^ parity_bit;

    assign data_last_c = (bit_cnt == BIT_CNT_W'(cfg_q.data_bits - DB_W'(1)));
    assign stop_last_c = (stop_cnt == (cfg_q.stop_bits - SB_W'(1)));

    // New bit period starts on every capture and at every bit boundary.
    assign baud_load_c = capture_c || ((state != ST_IDLE) && bit_done_c);
    assign baud_val_c  = capture_c ? bit_rate : br_q;

    uart_tx_baud_cnt #(
        .pBR_WIDTH (pBR_WIDTH)
    ) u_baud_cnt (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (baud_load_c),
        .load_val   (baud_val_c),
        .bit_done_c (bit_done_c)
    );

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            txd     <= 1'b1;
            txd_ack <= 1'b0;
            tx_busy <= 1'b0;
        end else begin
            state   <= state_nxt;
            txd     <= txd_nxt;
            txd_ack <= ack_nxt;
            tx_busy <= busy_nxt;
        end
    end

    // Next state; requests are only taken in IDLE or on the final stop-bit cycle.
    always_comb begin
        state_nxt = state;
        capture_c = 1'b0;
        case (state)
            ST_IDLE: begin
                if (txd_syn) begin
                    capture_c = 1'b1;
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (bit_done_c) state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (bit_done_c && data_last_c) begin
                    state_nxt = cfg_q.parity_en ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (bit_done_c) state_nxt = ST_STOP;
            end
            ST_STOP: begin
                if (bit_done_c && stop_last_c) begin
                    if (txd_syn) begin
                        capture_c = 1'b1;
                        state_nxt = ST_START;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Next output values; a new data bit comes from shreg[0] after START, else from shreg[1]
    // since the register shifts on the same edge the bit changes.
    always_comb begin
        txd_nxt  = 1'b1;
        ack_nxt  = capture_c;
        busy_nxt = (state_nxt != ST_IDLE);
        case (state_nxt)
            ST_START:  txd_nxt = 1'b0;
            ST_DATA: begin
                if (!bit_done_c)            txd_nxt = txd;
                else if (state == ST_DATA)  txd_nxt = shreg[1];
                else                        txd_nxt = shreg[0];
            end
            ST_PARITY: txd_nxt = par_q;
            default:   txd_nxt = 1'b1;
        endcase
    end

    // Capture registers, shift register and bit/stop counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shreg    <= '0;
            bit_cnt  <= '0;
            stop_cnt <= '0;
            cfg_q    <= '0;
            br_q     <= '0;
            par_q    <= 1'b0;
        end else if (capture_c) begin
            shreg    <= txd_data;
            bit_cnt  <= '0;
            stop_cnt <= '0;
            cfg_q    <= cfg_c;
            br_q     <= bit_rate;
            par_q    <= par_c;
        end else if (bit_done_c) begin
            if (state == ST_DATA && !data_last_c) begin
                shreg   <= shreg >> 1;
                bit_cnt <= bit_cnt + BIT_CNT_W'(1);
            end
            if (state == ST_STOP) begin
                stop_cnt <= stop_cnt + SB_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: per-cycle txd/ack/busy waveforms compared against
// frames built bit by bit from the frame rules.
`timescale 1ns/1ps
module tb_uart_tx;

    localparam int unsigned BR_W = 16;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [BR_W-1:0] bit_rate;
    logic [3:0]      data_bits;
    logic [1:0]      stop_bits;
    logic            parity_bit;
    logic            parity_enabled;
    logic            txd_syn;
    logic [7:0]      txd_data;
    logic            txd_ack;
    logic            txd;
    logic            tx_busy;

    int checks = 0;
    int errors = 0;

    logic rec_txd[$];
    logic rec_ack[$];
    logic rec_busy[$];
    logic exp_txd[$];
    logic exp_ack[$];
    logic exp_busy[$];

    uart_tx #(.pBR_WIDTH(BR_W)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .bit_rate       (bit_rate),
        .data_bits      (data_bits),
        .stop_bits      (stop_bits),
        .parity_bit     (parity_bit),
        .parity_enabled (parity_enabled),
        .txd_syn        (txd_syn),
        .txd_data       (txd_data),
        .txd_ack        (txd_ack),
        .txd            (txd),
        .tx_busy        (tx_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: appends the expected per-cycle waveform of one frame.
    task automatic add_frame(input logic [7:0] data, input int db, input int ns,
                             input bit pe, input bit po, input int br);
        logic bits[$];
        int   ones;
        ones = 0;
        bits.push_back(1'b0);
        for (int i = 0; i < db; i++) begin
            bits.push_back(data[i]);
            ones += int'(data[i]);
        end
        if (pe) bits.push_back(((ones % 2) == 1) ^ po);
        for (int i = 0; i < ns; i++) bits.push_back(1'b1);
        foreach (bits[i]) begin
            for (int k = 0; k <= br; k++) begin
                exp_txd.push_back(bits[i]);
                exp_ack.push_back(i == 0 && k == 0);
                exp_busy.push_back(1'b1);
            end
        end
    endtask

    task automatic add_idle(input int n);
        for (int i = 0; i < n; i++) begin
            exp_txd.push_back(1'b1);
            exp_ack.push_back(1'b0);
            exp_busy.push_back(1'b0);
        end
    endtask

    task automatic clear_exp();
        exp_txd.delete();
        exp_ack.delete();
        exp_busy.delete();
    endtask

    task automatic request(input logic [7:0] data, input int db, input int sb,
                           input bit pe, input bit po, input int br);
        @(negedge clk);
        txd_data       = data;
        data_bits      = 4'(db);
        stop_bits      = 2'(sb);
        parity_enabled = pe;
        parity_bit     = po;
        bit_rate       = BR_W'(br);
        txd_syn        = 1'b1;
    endtask

    // Samples n cycles; drops syn after sample drop_at, pokes bit_rate/data after sample poke_at.
    task automatic record(input int n, input int drop_at, input int poke_at,
                          input int poke_br, input logic [7:0] poke_data);
        rec_txd.delete();
        rec_ack.delete();
        rec_busy.delete();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rec_txd.push_back(txd);
            rec_ack.push_back(txd_ack);
            rec_busy.push_back(tx_busy);
            if (i == drop_at) txd_syn = 1'b0;
            if (i == poke_at) begin
                bit_rate = BR_W'(poke_br);
                txd_data = poke_data;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({txd, txd_ack, tx_busy} !== 3'b100) begin
            errors++;
            $display("FAIL reset_state txd/ack/busy=%b%b%b exp 100", txd, txd_ack, tx_busy);
        end
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({txd, txd_ack, tx_busy} !== 3'b100) begin
            errors++;
            $display("FAIL post_reset_idle txd/ack/busy=%b%b%b exp 100", txd, txd_ack, tx_busy);
        end
    endtask

    task automatic test_8n1();
        int t1[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
        int busy_cnt;
        request(8'hA5, 8, 1, 1'b0, 1'b0, 3);
        clear_exp();
        add_frame(8'hA5, 8, 1, 1'b0, 1'b0, 3);
        add_idle(1);
        record(exp_txd.size(), 0, -1, 0, 8'h00);
        for (int i = 0; i < exp_txd.size(); i++) begin
            checks++;
            if ({rec_txd[i], rec_ack[i], rec_busy[i]} !== {exp_txd[i], exp_ack[i], exp_busy[i]}) begin
                errors++;
                $display("FAIL 8n1_wave cyc %0d txd/ack/busy=%b%b%b exp %b%b%b", i,
                         rec_txd[i], rec_ack[i], rec_busy[i], exp_txd[i], exp_ack[i], exp_busy[i]);
            end
        end
        for (int b = 0; b < 10; b++) begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (rec_txd[b*4+k] !== 1'(t1[b])) begin
                    errors++;
                    $display("FAIL 8n1_bit %0d cyc %0d txd=%b exp %0d", b, k, rec_txd[b*4+k], t1[b]);
                end
            end
        end
        busy_cnt = 0;
        foreach (rec_busy[i]) busy_cnt += int'(rec_busy[i] === 1'b1);
        checks++;
        if (busy_cnt != 40) begin
            errors++;
            $display("FAIL 8n1_frame_len busy cycles=%0d exp 40", busy_cnt);
        end
    endtask

    task automatic test_parity();
        logic [7:0] pdata[3] = '{8'hA5, 8'hA5, 8'hFF};
        int         pdb[3]   = '{8, 8, 7};
        bit         ppo[3]   = '{1'b1, 1'b0, 1'b0};
        bit         pexp[3]  = '{1'b1, 1'b0, 1'b1};
        int         br;
        for (int c = 0; c < 3; c++) begin
            br = int'($urandom_range(0, 3));
            request(pdata[c], pdb[c], 1, 1'b1, ppo[c], br);
            clear_exp();
            add_frame(pdata[c], pdb[c], 1, 1'b1, ppo[c], br);
            add_idle(1);
            record(exp_txd.size(), 0, -1, 0, 8'h00);
            for (int i = 0; i < exp_txd.size(); i++) begin
                checks++;
                if ({rec_txd[i], rec_ack[i], rec_busy[i]} !== {exp_txd[i], exp_ack[i], exp_busy[i]}) begin
                    errors++;
                    $display("FAIL parity_wave case %0d cyc %0d txd/ack/busy=%b%b%b exp %b%b%b", c, i,
                             rec_txd[i], rec_ack[i], rec_busy[i], exp_txd[i], exp_ack[i], exp_busy[i]);
                end
            end
            checks++;
            if (rec_txd[(1 + pdb[c]) * (br + 1)] !== pexp[c]) begin
                errors++;
                $display("FAIL parity_bit case %0d txd=%b exp %b", c,
                         rec_txd[(1 + pdb[c]) * (br + 1)], pexp[c]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int br;
        int l1;
        int acks;
        br = int'($urandom_range(1, 3));
        l1 = (1 + 8 + 2) * (br + 1);
        request(8'h00, 8, 2, 1'b0, 1'b0, br);
        clear_exp();
        add_frame(8'h00, 8, 2, 1'b0, 1'b0, br);
        add_frame(8'hFF, 8, 2, 1'b0, 1'b0, br);
        add_idle(1);
        record(exp_txd.size(), l1, 0, br, 8'hFF);
        for (int i = 0; i < exp_txd.size(); i++) begin
            checks++;
            if ({rec_txd[i], rec_ack[i], rec_busy[i]} !== {exp_txd[i], exp_ack[i], exp_busy[i]}) begin
                errors++;
                $display("FAIL b2b_wave cyc %0d txd/ack/busy=%b%b%b exp %b%b%b", i,
                         rec_txd[i], rec_ack[i], rec_busy[i], exp_txd[i], exp_ack[i], exp_busy[i]);
            end
        end
        acks = 0;
        foreach (rec_ack[i]) acks += int'(rec_ack[i] === 1'b1);
        checks++;
        if (acks != 2) begin
            errors++;
            $display("FAIL b2b_ack_count acks=%0d exp 2", acks);
        end
    endtask

    task automatic test_clamp();
        int cdb[4]  = '{0, 12, 5, 9};
        int csb[4]  = '{0, 3, 1, 2};
        int edb[4]  = '{8, 8, 5, 8};
        int ens[4]  = '{1, 2, 1, 2};
        int cbr[4]  = '{0, 0, 1, 0};
        logic [7:0] d;
        for (int c = 0; c < 4; c++) begin
            d = 8'($urandom);
            request(d, cdb[c], csb[c], 1'b0, 1'b0, cbr[c]);
            clear_exp();
            add_frame(d, edb[c], ens[c], 1'b0, 1'b0, cbr[c]);
            add_idle(1);
            record(exp_txd.size(), 0, -1, 0, d);
            for (int i = 0; i < exp_txd.size(); i++) begin
                checks++;
                if ({rec_txd[i], rec_ack[i], rec_busy[i]} !== {exp_txd[i], exp_ack[i], exp_busy[i]}) begin
                    errors++;
                    $display("FAIL clamp_wave case %0d cyc %0d txd/ack/busy=%b%b%b exp %b%b%b", c, i,
                             rec_txd[i], rec_ack[i], rec_busy[i], exp_txd[i], exp_ack[i], exp_busy[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d;
        d = 8'($urandom);
        request(d, 8, 1, 1'b0, 1'b0, 3);
        clear_exp();
        add_frame(d, 8, 1, 1'b0, 1'b0, 3);
        record(18, 0, -1, 0, d);
        for (int i = 0; i < 18; i++) begin
            checks++;
            if ({rec_txd[i], rec_ack[i], rec_busy[i]} !== {exp_txd[i], exp_ack[i], exp_busy[i]}) begin
                errors++;
                $display("FAIL rstmid_prefix cyc %0d txd/ack/busy=%b%b%b exp %b%b%b", i,
                         rec_txd[i], rec_ack[i], rec_busy[i], exp_txd[i], exp_ack[i], exp_busy[i]);
            end
        end
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if ({txd, txd_ack, tx_busy} !== 3'b100) begin
            errors++;
            $display("FAIL rstmid_async txd/ack/busy=%b%b%b exp 100", txd, txd_ack, tx_busy);
        end
        @(negedge clk);
        reset_n = 1'b1;
        clear_exp();
        add_idle(4);
        record(4, -1, -1, 0, d);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({rec_txd[i], rec_ack[i], rec_busy[i]} !== {exp_txd[i], exp_ack[i], exp_busy[i]}) begin
                errors++;
                $display("FAIL rstmid_idle cyc %0d txd/ack/busy=%b%b%b exp %b%b%b", i,
                         rec_txd[i], rec_ack[i], rec_busy[i], exp_txd[i], exp_ack[i], exp_busy[i]);
            end
        end
        d = 8'($urandom);
        request(d, 8, 1, 1'b0, 1'b0, 3);
        clear_exp();
        add_frame(d, 8, 1, 1'b0, 1'b0, 3);
        add_idle(1);
        record(exp_txd.size(), 0, -1, 0, d);
        for (int i = 0; i < exp_txd.size(); i++) begin
            checks++;
            if ({rec_txd[i], rec_ack[i], rec_busy[i]} !== {exp_txd[i], exp_ack[i], exp_busy[i]}) begin
                errors++;
                $display("FAIL rstmid_clean cyc %0d txd/ack/busy=%b%b%b exp %b%b%b", i,
                         rec_txd[i], rec_ack[i], rec_busy[i], exp_txd[i], exp_ack[i], exp_busy[i]);
            end
        end
    endtask

    task automatic test_cfg_change();
        logic [7:0] d1;
        logic [7:0] d2;
        d1 = 8'($urandom);
        d2 = 8'($urandom);
        request(d1, 8, 1, 1'b0, 1'b0, 3);
        clear_exp();
        add_frame(d1, 8, 1, 1'b0, 1'b0, 3);
        add_idle(1);
        record(exp_txd.size(), 0, 10, 7, d1);
        for (int i = 0; i < exp_txd.size(); i++) begin
            checks++;
            if ({rec_txd[i], rec_ack[i], rec_busy[i]} !== {exp_txd[i], exp_ack[i], exp_busy[i]}) begin
                errors++;
                $display("FAIL cfgchg_cur cyc %0d txd/ack/busy=%b%b%b exp %b%b%b", i,
                         rec_txd[i], rec_ack[i], rec_busy[i], exp_txd[i], exp_ack[i], exp_busy[i]);
            end
        end
        request(d2, 8, 1, 1'b0, 1'b0, 7);
        clear_exp();
        add_frame(d2, 8, 1, 1'b0, 1'b0, 7);
        add_idle(1);
        record(exp_txd.size(), 0, -1, 0, d2);
        for (int i = 0; i < exp_txd.size(); i++) begin
            checks++;
            if ({rec_txd[i], rec_ack[i], rec_busy[i]} !== {exp_txd[i], exp_ack[i], exp_busy[i]}) begin
                errors++;
                $display("FAIL cfgchg_next cyc %0d txd/ack/busy=%b%b%b exp %b%b%b", i,
                         rec_txd[i], rec_ack[i], rec_busy[i], exp_txd[i], exp_ack[i], exp_busy[i]);
            end
        end
    endtask

    task automatic test_random();
        int         db;
        int         sb;
        int         br;
        int         edb;
        int         ens;
        bit         pe;
        bit         po;
        logic [7:0] d;
        for (int n = 0; n < 20; n++) begin
            db  = int'($urandom_range(0, 15));
            sb  = int'($urandom_range(0, 3));
            br  = int'($urandom_range(0, 4));
            pe  = 1'($urandom);
            po  = 1'($urandom);
            d   = 8'($urandom);
            edb = (db == 0 || db > 8) ? 8 : db;
            ens = (sb >= 2) ? 2 : 1;
            request(d, db, sb, pe, po, br);
            clear_exp();
            add_frame(d, edb, ens, pe, po, br);
            add_idle(1);
            record(exp_txd.size(), 0, -1, br, d);
            for (int i = 0; i < exp_txd.size(); i++) begin
                checks++;
                if ({rec_txd[i], rec_ack[i], rec_busy[i]} !== {exp_txd[i], exp_ack[i], exp_busy[i]}) begin
                    errors++;
                    $display("FAIL random_wave frame %0d cyc %0d txd/ack/busy=%b%b%b exp %b%b%b", n, i,
                             rec_txd[i], rec_ack[i], rec_busy[i], exp_txd[i], exp_ack[i], exp_busy[i]);
                end
            end
        end
    endtask

    initial begin
        bit_rate       = '0;
        data_bits      = 4'd8;
        stop_bits      = 2'd1;
        parity_bit     = 1'b0;
        parity_enabled = 1'b0;
        txd_syn        = 1'b0;
        txd_data       = 8'h00;
        test_reset();
        test_8n1();
        test_parity();
        test_back_to_back();
        test_clamp();
        test_reset_mid_frame();
        test_cfg_change();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
